id_ex_operand_stage: RTL

- Decode-to-execute pipeline stage directly downstream of the register file.
- Takes the two combinational read operands from the register file and applies a WB→ID bypass. The bypass is needed because register-file writes only land at the clock edge.
- Detects load-use hazards, inserts bubbles, and registers the decoded instruction into the EX stage, with stall and flush.
- EX/MEM→EX forwarding is out of scope and lives in the EX-stage forwarding unit.

---
 rtl/id_ex_operand_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ID->EX operand stage: WB->ID bypass, load-use bubble insertion, stall/flush handling.
// Optional stall counters are enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_is_load,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              id_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_is_load
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_hold_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
    logic              is_load;
  } ex_reg_t;

  ex_reg_t         ex_d, ex_q;
  logic [XLEN-1:0] byp1, byp2;
  logic            load_use;

  always_comb begin
    // The register file only commits at the edge, so a same-cycle WB write must be forwarded.
    byp1 = (wb_we && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_wd : id_rd1;
    byp2 = (wb_we && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_wd : id_rd2;

    load_use = ex_q.valid && ex_q.is_load && ex_q.rd != 5'd0 && id_valid &&
               ((id_uses_rs1 && id_rs1 == ex_q.rd) || (id_uses_rs2 && id_rs2 == ex_q.rd));

    // NOTE: ex_d defaults to ex_q so every path assigns it; a missing default here infers latches.
    ex_d = ex_q;
    if (flush) begin
      ex_d.valid   = 1'b0;
      ex_d.ctrl    = '0;
      ex_d.is_load = 1'b0;
    end else if (ex_ready) begin
      if (load_use) begin
        ex_d.valid   = 1'b0;
        ex_d.ctrl    = '0;
        ex_d.is_load = 1'b0;
      end else begin
        ex_d.valid   = id_valid;
        ex_d.pc      = id_pc;
        ex_d.imm     = id_imm;
        ex_d.op1     = byp1;
        ex_d.op2     = byp2;
        ex_d.rs1     = id_rs1;
        ex_d.rs2     = id_rs2;
        ex_d.rd      = id_rd;
        ex_d.ctrl    = id_ctrl;
        ex_d.is_load = id_is_load;
      end
    end
  end

  // Gated by rst so IF/ID never advances while the stage is held in reset.
  assign id_ready = !rst && (flush || (ex_ready && !load_use));

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ex_valid   = ex_q.valid;
  assign ex_pc      = ex_q.pc;
  assign ex_imm     = ex_q.imm;
  assign ex_op1     = ex_q.op1;
  assign ex_op2     = ex_q.op2;
  assign ex_rs1     = ex_q.rs1;
  assign ex_rs2     = ex_q.rs2;
  assign ex_rd      = ex_q.rd;
  assign ex_ctrl    = ex_q.ctrl;
  assign ex_is_load = ex_q.is_load;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic [31:0] hold_cnt_d, hold_cnt_q;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q + {31'd0, (!flush && ex_ready && load_use)};
    hold_cnt_d   = hold_cnt_q + {31'd0, (!flush && !ex_ready)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_hold_cnt   = hold_cnt_q;
`else
  // Stall counters are not built in this configuration.
`endif

endmodule
